// File: rtl/board_cell_store.sv
// Registered store for one board row of CELL_W-bit cell codes.
// Clocked write port with occupancy rule, sequential clear sweep and live stone count.
module board_cell_store #(
    parameter int CELL_W    = 2,
    parameter int CELLS     = 16,
    parameter int SEL_W     = 4,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [SEL_W-1:0]        wr_sel,
    input  logic [CELL_W-1:0]       wr_data,
    input  logic                    clear_req,
    input  logic [SEL_W-1:0]        rd_sel,
    output logic [CELL_W-1:0]       rd_data,
    output logic [CELLS*CELL_W-1:0] row_out,
    output logic                    wr_ack,
    output logic                    wr_reject,
    output logic                    busy,
    output logic                    clear_done,
    output logic [SEL_W:0]          stone_count,
    output logic                    full
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [SEL_W:0]   CELLS_V = (SEL_W+1)'(CELLS);
    localparam logic [SEL_W-1:0] LAST_IX = SEL_W'(CELLS - 1);

    state_t             state;
    logic [SEL_W-1:0]   sweep_ix;
    logic [CELL_W-1:0]  cells [CELLS];

    logic               wr_in_range;
    logic               rd_in_range;
    logic [CELL_W-1:0]  wr_cur;
    logic               wr_accept;

    assign wr_in_range = {1'b0, wr_sel} < CELLS_V;
    assign rd_in_range = {1'b0, rd_sel} < CELLS_V;
    assign wr_cur      = wr_in_range ? cells[wr_sel] : '0;
    assign wr_accept   = wr_in_range && (OVERWRITE || wr_cur == '0);

    assign rd_data = rd_in_range ? cells[rd_sel] : '0;
    assign busy    = (state == CLEAR);
    assign full    = (stone_count == CELLS_V);

    always_comb begin
        row_out = '0;
        for (int i = 0; i < CELLS; i++) begin
            row_out[i*CELL_W +: CELL_W] = cells[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sweep_ix    <= '0;
            stone_count <= '0;
            wr_ack      <= 1'b0;
            wr_reject   <= 1'b0;
            clear_done  <= 1'b0;
            // NOTE: the cell array is a bank of flops that must read as empty straight
            // out of reset (row_out feeds win-check), so it is reset like any other register.
            for (int i = 0; i < CELLS; i++) begin
                cells[i] <= '0;
            end
        end else begin
            wr_ack     <= 1'b0;
            wr_reject  <= 1'b0;
            clear_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clear_req) begin
                        state     <= CLEAR;
                        sweep_ix  <= '0;
                        wr_reject <= wr_en;
                    end else if (wr_en) begin
                        if (wr_accept) begin
                            cells[wr_sel] <= wr_data;
                            wr_ack        <= 1'b1;
                            if (wr_cur == '0 && wr_data != '0) begin
                                stone_count <= stone_count + 1'b1;
                            end else if (wr_cur != '0 && wr_data == '0) begin
                                stone_count <= stone_count - 1'b1;
                            end
                        end else begin
                            wr_reject <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    // The sweep owns the row: any write request is refused, clear_req ignored.
                    wr_reject       <= wr_en;
                    cells[sweep_ix] <= '0;
                    if (sweep_ix == LAST_IX) begin
                        state       <= IDLE;
                        stone_count <= '0;
                        clear_done  <= 1'b1;
                    end else begin
                        sweep_ix <= sweep_ix + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_cell_store.sv
// Self-checking bench for board_cell_store: three instances (default, OVERWRITE=1,
// CELLS=12) share stimulus and are each compared against a cell-array reference model.
module tb_board_cell_store;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic       clear_req = 1'b0;
    logic [3:0] wr_sel = '0;
    logic [3:0] rd_sel = '0;
    logic [1:0] wr_data = '0;

    logic [1:0]  rdd [3];
    logic [31:0] row0, row1;
    logic [23:0] row2;
    logic [4:0]  cnt [3];
    logic [2:0]  ack, rej, bsy, done, full;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    board_cell_store #(.CELL_W(2), .CELLS(16), .SEL_W(4), .OVERWRITE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .clear_req(clear_req), .rd_sel(rd_sel), .rd_data(rdd[0]), .row_out(row0),
        .wr_ack(ack[0]), .wr_reject(rej[0]), .busy(bsy[0]), .clear_done(done[0]),
        .stone_count(cnt[0]), .full(full[0]));

    board_cell_store #(.CELL_W(2), .CELLS(16), .SEL_W(4), .OVERWRITE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .clear_req(clear_req), .rd_sel(rd_sel), .rd_data(rdd[1]), .row_out(row1),
        .wr_ack(ack[1]), .wr_reject(rej[1]), .busy(bsy[1]), .clear_done(done[1]),
        .stone_count(cnt[1]), .full(full[1]));

    board_cell_store #(.CELL_W(2), .CELLS(12), .SEL_W(4), .OVERWRITE(1'b0)) dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .clear_req(clear_req), .rd_sel(rd_sel), .rd_data(rdd[2]), .row_out(row2),
        .wr_ack(ack[2]), .wr_reject(rej[2]), .busy(bsy[2]), .clear_done(done[2]),
        .stone_count(cnt[2]), .full(full[2]));

    // Reference model: plain cell array per instance plus sweep bookkeeping.
    int mc [3][16];
    int mcnt [3];
    int mpos [3];
    bit msweep [3];
    bit mack [3];
    bit mrej [3];
    bit mdone [3];

    function automatic int ncells(int k);
        return (k == 2) ? 12 : 16;
    endfunction

    function automatic bit ovw(int k);
        return k == 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) mc[k][i] = 0;
            mcnt[k] = 0; mpos[k] = 0; msweep[k] = 0;
            mack[k] = 0; mrej[k] = 0; mdone[k] = 0;
        end
    endtask

    task automatic model_step(int k);
        int sel;
        sel = int'(wr_sel);
        mack[k] = 0; mrej[k] = 0; mdone[k] = 0;
        if (msweep[k]) begin
            mrej[k] = wr_en;
            mc[k][mpos[k]] = 0;
            mpos[k]++;
            if (mpos[k] == ncells(k)) begin
                msweep[k] = 0;
                mcnt[k] = 0;
                mdone[k] = 1;
            end
        end else if (clear_req) begin
            msweep[k] = 1;
            mpos[k] = 0;
            mrej[k] = wr_en;
        end else if (wr_en) begin
            if (sel >= ncells(k) || (!ovw(k) && mc[k][sel] != 0)) begin
                mrej[k] = 1;
            end else begin
                mc[k][sel] = int'(wr_data);
                mack[k] = 1;
                mcnt[k] = 0;
                for (int i = 0; i < ncells(k); i++) if (mc[k][i] != 0) mcnt[k]++;
            end
        end
    endtask

    function automatic logic [41:0] exp_status(int k);
        logic [31:0] row;
        logic [4:0]  c;
        row = '0;
        for (int i = 0; i < ncells(k); i++) row[i*2 +: 2] = mc[k][i][1:0];
        c = 5'(mcnt[k]);
        return {row, c, mcnt[k] == ncells(k), mack[k], mrej[k], msweep[k], mdone[k]};
    endfunction

    function automatic logic [41:0] act_status(int k);
        logic [31:0] row;
        row = (k == 0) ? row0 : (k == 1) ? row1 : {8'h00, row2};
        return {row, cnt[k], full[k], ack[k], rej[k], bsy[k], done[k]};
    endfunction

    function automatic logic [1:0] exp_rd(int k);
        return (int'(rd_sel) < ncells(k)) ? mc[k][rd_sel][1:0] : 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset) for (int k = 0; k < 3; k++) model_step(k);
        #1;
    endtask

    task automatic set_in(bit we, int sel, int d, bit clr);
        wr_en = we;
        wr_sel = 4'(sel);
        wr_data = 2'(d);
        clear_req = clr;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0);
        #1 reset = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act_status(k) !== exp_status(k)) begin
                errors++;
                $display("FAIL reset dut%0d got=%h exp=%h", k, act_status(k), exp_status(k));
            end
        end
        #1 reset = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act_status(k) !== exp_status(k)) begin
                errors++;
                $display("FAIL reset_idle dut%0d got=%h exp=%h", k, act_status(k), exp_status(k));
            end
        end
    endtask

    task automatic test_write_rules();
        int sels [5] = '{3, 3, 3, 12, 13};
        int dats [5] = '{1, 2, 0, 1, 3};
        for (int s = 0; s < 5; s++) begin
            set_in(1, sels[s], dats[s], 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_status(k) !== exp_status(k)) begin
                    errors++;
                    $display("FAIL write_rules step%0d dut%0d got=%h exp=%h",
                             s, k, act_status(k), exp_status(k));
                end
            end
            if (s == 0) begin
                checks++;
                if (row0[7:6] !== 2'b01 || ack[0] !== 1'b1 || cnt[0] !== 5'd1) begin
                    errors++;
                    $display("FAIL first_write got cell=%b ack=%b cnt=%0d exp cell=01 ack=1 cnt=1",
                             row0[7:6], ack[0], cnt[0]);
                end
            end
        end
        set_in(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_fill();
        int nack;
        pulse_reset();
        nack = 0;
        for (int i = 0; i < 16; i++) begin
            set_in(1, i, 2, 0);
            tick();
            if (ack[0]) nack++;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_status(k) !== exp_status(k)) begin
                    errors++;
                    $display("FAIL fill cell%0d dut%0d got=%h exp=%h", i, k, act_status(k), exp_status(k));
                end
            end
        end
        set_in(0, 0, 0, 0);
        checks++;
        if (row0 !== 32'hAAAAAAAA || full[0] !== 1'b1 || cnt[0] !== 5'd16 || nack != 16) begin
            errors++;
            $display("FAIL fill_full got row=%h full=%b cnt=%0d acks=%0d exp row=aaaaaaaa full=1 cnt=16 acks=16",
                     row0, full[0], cnt[0], nack);
        end
    endtask

    task automatic test_clear();
        int nbusy, ndone;
        set_in(1, 5, 1, 1);
        tick();
        nbusy = bsy[0] ? 1 : 0;
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act_status(k) !== exp_status(k) || rej[k] !== 1'b1) begin
                errors++;
                $display("FAIL clear_collision dut%0d got=%h exp=%h", k, act_status(k), exp_status(k));
            end
        end
        for (int c = 0; c < 20; c++) begin
            set_in(($urandom_range(0, 1) == 1), $urandom_range(0, 15), $urandom_range(1, 3), 1'($urandom_range(0, 1)) && c < 10);
            tick();
            if (bsy[0]) nbusy++;
            if (done[0]) begin
                ndone++;
                checks++;
                if (row0 !== 32'h0 || full[0] !== 1'b0 || cnt[0] !== 5'd0) begin
                    errors++;
                    $display("FAIL clear_result got row=%h full=%b cnt=%0d exp row=0 full=0 cnt=0",
                             row0, full[0], cnt[0]);
                end
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_status(k) !== exp_status(k)) begin
                    errors++;
                    $display("FAIL clear_sweep cyc%0d dut%0d got=%h exp=%h", c, k, act_status(k), exp_status(k));
                end
            end
        end
        set_in(0, 0, 0, 0);
        checks++;
        if (nbusy != 16 || ndone != 1) begin
            errors++;
            $display("FAIL clear_timing got busy=%0d done=%0d exp busy=16 done=1", nbusy, ndone);
        end
    endtask

    task automatic test_read();
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            set_in(1, i, $urandom_range(1, 3), 0);
            tick();
        end
        set_in(0, 0, 0, 0);
        for (int r = 0; r < 16; r++) begin
            rd_sel = 4'(r);
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rdd[k] !== exp_rd(k)) begin
                    errors++;
                    $display("FAIL read sel%0d dut%0d got=%b exp=%b", r, k, rdd[k], exp_rd(k));
                end
            end
        end
        rd_sel = 4'd15;
        #1;
        checks++;
        if (rdd[2] !== 2'b00 || rdd[0] === 2'b00) begin
            errors++;
            $display("FAIL read_oob got dut2=%b dut0=%b exp dut2=00 dut0 nonzero", rdd[2], rdd[0]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        set_in(1, 10, 3, 0);
        tick();
        set_in(0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0);
        repeat (5) tick();
        #2 reset = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act_status(k) !== exp_status(k)) begin
                errors++;
                $display("FAIL reset_mid_sweep dut%0d got=%h exp=%h", k, act_status(k), exp_status(k));
            end
        end
        #1 reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_status(k) !== exp_status(k)) begin
                    errors++;
                    $display("FAIL after_reset cyc%0d dut%0d got=%h exp=%h", c, k, act_status(k), exp_status(k));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3),
                   ($urandom_range(0, 24) == 0));
            rd_sel = 4'($urandom_range(0, 15));
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_status(k) !== exp_status(k) || rdd[k] !== exp_rd(k)) begin
                    errors++;
                    $display("FAIL random cyc%0d dut%0d got=%h/%b exp=%h/%b",
                             c, k, act_status(k), rdd[k], exp_status(k), exp_rd(k));
                end
            end
        end
        set_in(0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_rules();
        test_fill();
        test_clear();
        test_read();
        test_reset_mid_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/board_cell_store.md
# board_cell_store

Parametrised, registered store for one board row of game cells, each cell a CELL_W-bit code (0 = empty, nonzero = stone owner). It replaces the combinational select-to-row steering with a clocked write port, an occupancy rule, a sequential clear sweep and a live stone count. It sits between the move-placement controller, which issues writes, and the win-check and VGA logic, which read row_out and rd_data.

## Interface
- CELL_W, 2, bits per cell code
- CELLS, 16, cells in the row
- SEL_W, 4, select width, must satisfy 2**SEL_W >= CELLS
- OVERWRITE, 0, 0 = writes to occupied cells rejected; 1 = any write to a valid index accepted
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write request, sampled each rising edge
- wr_sel  in  SEL_W  target cell index
- wr_data  in  CELL_W  cell code to store
- clear_req  in  1  start a clear sweep
- rd_sel  in  SEL_W  read index
- rd_data  out  CELL_W  combinational read of cell rd_sel; 0 if rd_sel >= CELLS
- row_out  out  CELLS*CELL_W  registered row; cell i at bits [i*CELL_W +: CELL_W]
- wr_ack  out  1  one-cycle pulse: previous-cycle write accepted
- wr_reject  out  1  one-cycle pulse: previous-cycle write refused
- busy  out  1  high while clear sweep in progress
- clear_done  out  1  one-cycle pulse after last cell cleared
- stone_count  out  SEL_W+1  number of nonzero cells
- full  out  1  stone_count == CELLS

## Operation
- Reset (async, any time including mid-sweep): row_out=0, stone_count=0, state IDLE, sweep index=0, wr_ack=wr_reject=busy=clear_done=0, full=0.
- FSM states: IDLE, CLEAR.
- IDLE, clear_req=1: go to CLEAR, index=0. A simultaneous wr_en is refused (wr_reject).
- IDLE, wr_en=1, clear_req=0: write refused if wr_sel >= CELLS, or if OVERWRITE=0 and cell nonzero. Otherwise cell <= wr_data, wr_ack.
- Count update on accepted write: empty->nonzero +1; nonzero->0 -1; otherwise unchanged. Writing 0 to an empty cell is accepted with no count change.
- CLEAR: each cycle zeroes cell[index] and increments index. Clearing cell CELLS-1 returns to IDLE, sets stone_count=0, and pulses clear_done next cycle. clear_req while in CLEAR is ignored.
- CLEAR, wr_en=1: refused (wr_reject); no cell modified.
- Exactly one of wr_ack/wr_reject pulses per sampled wr_en; neither when wr_en=0.
- full is derived from registered stone_count.

## Timing
- Write latency 1: wr_en sampled at edge N; row_out, stone_count and full update at N; wr_ack/wr_reject high from N to N+1.
- Back-to-back writes every cycle supported; each is judged against row state after the previous write.
- rd_data: zero-cycle combinational path from the registered row.
- busy rises at the edge sampling clear_req and stays high exactly CELLS cycles. The cell 0 zeroing occurs one edge after busy rises. clear_done is high the cycle after busy falls.
- A write accepted on the cycle immediately after clear_done lands normally.

## Test plan
- Reset mid-sweep: assert reset during CLEAR at index 5 -> row_out=0, busy=0, stone_count=0 immediately, no clear_done.
- OVERWRITE=0, write sel=3 data=2'b01 -> wr_ack, row_out[7:6]=01, count=1. Rewrite sel=3 data=2'b10 -> wr_reject, row unchanged, count=1.
- OVERWRITE=1, sel=3 01 then sel=3 00 -> two wr_ack, count 1 then 0. CELLS=12, write sel=13 -> wr_reject.
- Fill all 16 cells with 2'b10 on consecutive cycles -> 16 wr_ack, count=16, full=1, row_out=32'hAAAAAAAA.
- clear_req with wr_en in the same cycle -> wr_reject. busy is high for 16 cycles; write during busy -> wr_reject. clear_done is then one cycle, row_out=0, full=0.
- rd_sel sweep 0..15 after pattern load -> rd_data matches each cell same cycle. rd_sel=15 with CELLS=12 -> 0.
